ulpi_phy_responder: RTL and testbench
=====================================

Name: ulpi_phy_responder

Overview:
PHY-side counterpart of the FPGA ULPI link controller. It models the USB3300 end of the ULPI bus: it accepts TX CMD bytes from the link, answers register reads and writes against an internal register subset, sinks transmit packets, and issues RX CMD bytes when the line state changes. It is used as a bus-accurate responder for link-side verification and for loop-back bring-up on the ICEstick.

Parameters:
VENDOR_ID, 16'h0424, value returned at addresses 0x00 (low byte) and 0x01 (high byte)
PRODUCT_ID, 16'h0007, value returned at addresses 0x02 (low byte) and 0x03 (high byte)
FUNC_CTRL_RST, 8'h41, reset value of Function Control (0x04)
OTG_CTRL_RST, 8'h06, reset value of OTG Control (0x0A)

Ports:
clk_ext  in  1  60 MHz ULPI clock. This is the only clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset
ulpi_data_in  in  8  bus value driven by the link (valid when DIR=0)
ulpi_data_out  out  8  bus value driven by the PHY
ulpi_data_oe  out  1  PHY bus drive enable; always equals DIR
DIR  out  1  ULPI DIR
NXT  out  1  ULPI NXT
STP  in  1  ULPI STP from the link
linestate  in  2  current line state to report in RX CMD
reg_wr_strobe  out  1  one-cycle pulse when a register write commits
reg_wr_addr  out  6  address of the last committed write
tx_done  out  1  one-cycle pulse at the end of a transmit packet
tx_byte_count  out  10  bytes accepted after the TX CMD in the last packet; saturates at 1023

Behaviour:
- All outputs are registered. On reset: DIR=0, NXT=0, ulpi_data_out=0x00, strobes=0, tx_byte_count=0, state=IDLE, last_ls=2'b00, registers at their defaults.
- Reset mid-operation aborts the current transaction immediately. No write commits.

Register map:
- 0x00-0x03: IDs, read-only.
- 0x04/05/06: Function Control. Write, set, or clear.
- 0x07/08/09: Interface Control. Reset value 0x00.
- 0x0A/0B/0C: OTG Control.
- 0x16/17/18: Scratch. Reset value 0x00.
- Set (base+1): reg |= data. Clear (base+2): reg &= ~data.
- Reads at any alias return the base register.
- All other addresses, including extended 0x2F: read 0x00, writes are dropped with no strobe.

States: IDLE, WR_ACK, WR_DATA, WR_STP, RD_ACK, RD_TURN, RD_DATA, RXC_TURN, RXC_DATA, TX_PKT, TURNBACK.

- IDLE: samples ulpi_data_in. Let cmd be the byte sampled in cycle N.
  - cmd[7:6]=10: go to WR_ACK.
  - cmd[7:6]=11: go to RD_ACK.
  - cmd[7:6]=01: go to TX_PKT.
  - cmd[7:6]=00 and nonzero: ignored.
  - cmd=0x00, STP=0, linestate!=last_ls: go to RXC_TURN.
  - A nonzero cmd always wins over a pending RX CMD. The RX CMD stays pending because it compares against last_ls.
- Register write:
  - N+1, WR_ACK: NXT=1. If STP=1 is sampled here, abort to IDLE with no write.
  - N+2, WR_DATA: NXT=1; capture ulpi_data_in.
  - N+3, WR_STP: NXT=0; stay until STP=1 is sampled.
  - On the STP edge: commit the write, pulse reg_wr_strobe for one cycle, update reg_wr_addr, go to IDLE.
- Register read:
  - N+1, RD_ACK: NXT=1.
  - N+2, RD_TURN: DIR=1, data=0x00.
  - N+3, RD_DATA: DIR=1, data=reg[addr].
  - N+4, TURNBACK: DIR=0.
  - STP is ignored during a read.
- RX CMD:
  - RXC_TURN: DIR=1, NXT=0.
  - RXC_DATA: DIR=1, data={6'b0, linestate}; latch last_ls=linestate.
  - Then TURNBACK.
- TX_PKT: NXT=1 every cycle.
  - Count each cycle where NXT=1 and STP=0, excluding the first (command) cycle.
  - When STP=1 is sampled: NXT=0, pulse tx_done, publish the count, go to IDLE.
- TURNBACK: DIR=0 for one cycle, bus ignored, then IDLE.
- NXT is never high while DIR is high.

Test Plan:
- Reset, then read 0x00..0x03 -> returned bytes 0x24, 0x04, 0x07, 0x00; DIR high exactly 2 cycles per read; NXT high only at N+1.
- Write 0x55 to 0x16, STP at N+3, read back -> reg_wr_strobe pulses once with reg_wr_addr=0x16; read returns 0x55.
- Function Control: set 0x04 via 0x05, then clear 0x40 via 0x06 -> reads 0x41, 0x45, 0x05 in sequence.
- TXCMD 0x96 (write 0x16), STP asserted in WR_ACK -> no strobe; scratch unchanged; state returns to IDLE.
- linestate changes 00->01 while a read TXCMD arrives the same cycle -> read completes first; RX CMD 0x01 is driven after TURNBACK; no second RX CMD while linestate stays 01.
- TXCMD 0x41 followed by 5 data bytes, then STP -> NXT high for 6 cycles; tx_done pulses once; tx_byte_count=5; rst asserted mid-packet returns DIR=0 and NXT=0 the next cycle.

Source files
------------

// File: rtl/ulpi_phy_responder.sv
// rtl/ulpi_phy_responder.sv - USB3300-style ULPI PHY responder: register access, TX sink, RX CMD on line-state change
module ulpi_phy_responder #(
  parameter logic [15:0] VENDOR_ID     = 16'h0424,
  parameter logic [15:0] PRODUCT_ID    = 16'h0007,
  parameter logic [7:0]  FUNC_CTRL_RST = 8'h41,
  parameter logic [7:0]  OTG_CTRL_RST  = 8'h06
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       DIR,
  output logic       NXT,
  input  logic       STP,
  input  logic [1:0] linestate,
  output logic       reg_wr_strobe,
  output logic [5:0] reg_wr_addr,
  output logic       tx_done,
  output logic [9:0] tx_byte_count
);

  typedef enum logic [3:0] {
    IDLE, WR_ACK, WR_DATA, WR_STP, RD_ACK, RD_TURN, RD_DATA,
    RXC_TURN, RXC_DATA, TX_PKT, TURNBACK
  } state_t;

  state_t     state;
  logic [5:0] addr;
  logic [7:0] wr_data;
  logic [1:0] last_ls;
  logic [9:0] tx_cnt;
  logic [7:0] func_ctrl, if_ctrl, otg_ctrl, scratch;

  logic       wr_ok;
  logic [1:0] grp, op;
  logic [7:0] cur_val, wr_val, rd_val;

  // Each writable register has three aliases: base (write), base+1 (set), base+2 (clear).
  always_comb begin
    wr_ok = 1'b1;
    grp   = 2'd0;
    op    = 2'd0;
    case (addr)
      6'h04: begin grp = 2'd0; op = 2'd0; end
      6'h05: begin grp = 2'd0; op = 2'd1; end
      6'h06: begin grp = 2'd0; op = 2'd2; end
      6'h07: begin grp = 2'd1; op = 2'd0; end
      6'h08: begin grp = 2'd1; op = 2'd1; end
      6'h09: begin grp = 2'd1; op = 2'd2; end
      6'h0A: begin grp = 2'd2; op = 2'd0; end
      6'h0B: begin grp = 2'd2; op = 2'd1; end
      6'h0C: begin grp = 2'd2; op = 2'd2; end
      6'h16: begin grp = 2'd3; op = 2'd0; end
      6'h17: begin grp = 2'd3; op = 2'd1; end
      6'h18: begin grp = 2'd3; op = 2'd2; end
      default: wr_ok = 1'b0;
    endcase

    case (grp)
      2'd0:    cur_val = func_ctrl;
      2'd1:    cur_val = if_ctrl;
      2'd2:    cur_val = otg_ctrl;
      default: cur_val = scratch;
    endcase

    case (op)
      2'd0:    wr_val = wr_data;
      2'd1:    wr_val = cur_val | wr_data;
      default: wr_val = cur_val & ~wr_data;
    endcase

    if (wr_ok) begin
      rd_val = cur_val;
    end else begin
      case (addr)
        6'h00:   rd_val = VENDOR_ID[7:0];
        6'h01:   rd_val = VENDOR_ID[15:8];
        6'h02:   rd_val = PRODUCT_ID[7:0];
        6'h03:   rd_val = PRODUCT_ID[15:8];
        default: rd_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state         <= IDLE;
      DIR           <= 1'b0;
      ulpi_data_oe  <= 1'b0;
      NXT           <= 1'b0;
      ulpi_data_out <= 8'h00;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= 6'd0;
      tx_done       <= 1'b0;
      tx_byte_count <= 10'd0;
      tx_cnt        <= 10'd0;
      addr          <= 6'd0;
      wr_data       <= 8'h00;
      last_ls       <= 2'b00;
      func_ctrl     <= FUNC_CTRL_RST;
      if_ctrl       <= 8'h00;
      otg_ctrl      <= OTG_CTRL_RST;
      scratch       <= 8'h00;
    end else begin
      reg_wr_strobe <= 1'b0;
      tx_done       <= 1'b0;
      case (state)
        IDLE: begin
          addr <= ulpi_data_in[5:0];
          if (ulpi_data_in[7:6] == 2'b10) begin
            state <= WR_ACK;
            NXT   <= 1'b1;
          end else if (ulpi_data_in[7:6] == 2'b11) begin
            state <= RD_ACK;
            NXT   <= 1'b1;
          end else if (ulpi_data_in[7:6] == 2'b01) begin
            state  <= TX_PKT;
            NXT    <= 1'b1;
            tx_cnt <= 10'd0;
          end else if (ulpi_data_in == 8'h00 && !STP && linestate != last_ls) begin
            state         <= RXC_TURN;
            DIR           <= 1'b1;
            ulpi_data_oe  <= 1'b1;
            ulpi_data_out <= 8'h00;
          end
        end
        WR_ACK: begin
          if (STP) begin
            state <= IDLE;
            NXT   <= 1'b0;
          end else begin
            state <= WR_DATA;
          end
        end
        WR_DATA: begin
          wr_data <= ulpi_data_in;
          NXT     <= 1'b0;
          state   <= WR_STP;
        end
        WR_STP: begin
          if (STP) begin
            state <= IDLE;
            if (wr_ok) begin
              reg_wr_strobe <= 1'b1;
              reg_wr_addr   <= addr;
              case (grp)
                2'd0:    func_ctrl <= wr_val;
                2'd1:    if_ctrl   <= wr_val;
                2'd2:    otg_ctrl  <= wr_val;
                default: scratch   <= wr_val;
              endcase
            end
          end
        end
        RD_ACK: begin
          NXT           <= 1'b0;
          DIR           <= 1'b1;
          ulpi_data_oe  <= 1'b1;
          ulpi_data_out <= 8'h00;
          state         <= RD_TURN;
        end
        RD_TURN: begin
          ulpi_data_out <= rd_val;
          state         <= RD_DATA;
        end
        RXC_TURN: begin
          ulpi_data_out <= {6'b0, linestate};
          last_ls       <= linestate;
          state         <= RXC_DATA;
        end
        RD_DATA, RXC_DATA: begin
          DIR           <= 1'b0;
          ulpi_data_oe  <= 1'b0;
          ulpi_data_out <= 8'h00;
          state         <= TURNBACK;
        end
        TX_PKT: begin
          if (STP) begin
            NXT           <= 1'b0;
            tx_done       <= 1'b1;
            tx_byte_count <= tx_cnt;
            state         <= IDLE;
          end else if (tx_cnt != 10'h3FF) begin
            tx_cnt <= tx_cnt + 10'd1;
          end
        end
        TURNBACK: state <= IDLE;
        default: begin
          state         <= IDLE;
          DIR           <= 1'b0;
          ulpi_data_oe  <= 1'b0;
          NXT           <= 1'b0;
          ulpi_data_out <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// tb/tb_ulpi_phy_responder.sv - randomized bench for ulpi_phy_responder against a transaction-level model
module tb_ulpi_phy_responder;

  logic       clk_ext = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ulpi_data_in = 8'h00;
  logic       STP = 1'b0;
  logic [1:0] linestate = 2'b00;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe, DIR, NXT, reg_wr_strobe, tx_done;
  logic [5:0] reg_wr_addr;
  logic [9:0] tx_byte_count;

  ulpi_phy_responder dut (
    .clk_ext(clk_ext), .rst(rst), .ulpi_data_in(ulpi_data_in),
    .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe),
    .DIR(DIR), .NXT(NXT), .STP(STP), .linestate(linestate),
    .reg_wr_strobe(reg_wr_strobe), .reg_wr_addr(reg_wr_addr),
    .tx_done(tx_done), .tx_byte_count(tx_byte_count)
  );

  always #8 clk_ext = ~clk_ext;

  int n_vec = 0;
  int n_err = 0;

  logic       check_en = 1'b0;
  logic       e_dir, e_nxt, e_strobe, e_done;
  logic [7:0] e_data;
  logic [5:0] e_addr;
  logic [9:0] e_cnt;

  // Model state: register contents and the bus-visible history the spec defines.
  logic [7:0] m_func, m_if, m_otg, m_scr;
  logic [1:0] m_last_ls;
  logic [5:0] m_addr;
  logic [9:0] m_cnt;
  logic [7:0] rx_seen;
  int         nxt_hi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_ext) begin
    if (check_en) begin
      chk("dir", 32'(DIR), 32'(e_dir));
      chk("oe", 32'(ulpi_data_oe), 32'(e_dir));
      chk("nxt", 32'(NXT), 32'(e_nxt));
      chk("data_out", 32'(ulpi_data_out), 32'(e_data));
      chk("wr_strobe", 32'(reg_wr_strobe), 32'(e_strobe));
      chk("wr_addr", 32'(reg_wr_addr), 32'(e_addr));
      chk("tx_done", 32'(tx_done), 32'(e_done));
      chk("tx_count", 32'(tx_byte_count), 32'(e_cnt));
    end
  end

  function automatic logic [7:0] r8();
    return 8'($urandom);
  endfunction

  function automatic int base_of(input logic [5:0] a);
    if (a >= 6'h04 && a <= 6'h06) return 4;
    if (a >= 6'h07 && a <= 6'h09) return 7;
    if (a >= 6'h0A && a <= 6'h0C) return 10;
    if (a >= 6'h16 && a <= 6'h18) return 22;
    return -1;
  endfunction

  function automatic logic [7:0] m_read(input logic [5:0] a);
    logic [31:0] ids;
    int i;
    ids = {16'h0007, 16'h0424};
    i = int'(a);
    if (i < 4) return ids[i*8 +: 8];
    case (base_of(a))
      4:       return m_func;
      7:       return m_if;
      10:      return m_otg;
      22:      return m_scr;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit m_write(input logic [5:0] a, input logic [7:0] d);
    int lo, off;
    logic [7:0] cur, nv;
    lo = base_of(a);
    if (lo < 0) return 1'b0;
    cur = m_read(6'(lo));
    off = int'(a) - lo;
    nv = (off == 0) ? d : (off == 1) ? (cur | d) : (cur & ~d);
    case (lo)
      4:       m_func = nv;
      7:       m_if   = nv;
      10:      m_otg  = nv;
      default: m_scr  = nv;
    endcase
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_func = 8'h41; m_if = 8'h00; m_otg = 8'h06; m_scr = 8'h00;
    m_last_ls = 2'b00; m_addr = 6'd0; m_cnt = 10'd0;
  endtask

  // One clock: apply inputs, then publish what the outputs must be after the edge.
  task automatic step(input logic [7:0] d, input logic s, input logic [1:0] ls,
                      input logic xd, input logic xn, input logic [7:0] xdata,
                      input logic xs, input logic xdone);
    ulpi_data_in = d; STP = s; linestate = ls;
    @(posedge clk_ext); #1;
    e_dir = xd; e_nxt = xn; e_data = xdata; e_strobe = xs; e_done = xdone;
    e_addr = m_addr; e_cnt = m_cnt;
    check_en = 1'b1;
    @(negedge clk_ext); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    m_reset();
    repeat (cycles) step(r8(), 1'($urandom), linestate, 0, 0, 8'h00, 0, 0);
    rst = 1'b0;
  endtask

  task automatic idle(input logic [1:0] ls, input logic s);
    if (!s && ls != m_last_ls) begin
      step(8'h00, 1'b0, ls, 1, 0, 8'h00, 0, 0);
      step(r8(), 1'($urandom), ls, 1, 0, {6'b0, ls}, 0, 0);
      rx_seen = ulpi_data_out;
      m_last_ls = ls;
      step(r8(), 1'($urandom), ls, 0, 0, 8'h00, 0, 0);
      step(r8(), 1'($urandom), ls, 0, 0, 8'h00, 0, 0);
    end else begin
      step(8'h00, s, ls, 0, 0, 8'h00, 0, 0);
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [1:0] ls, output logic [7:0] got);
    step({2'b11, a}, 1'b0, ls, 0, 1, 8'h00, 0, 0);
    step(r8(), 1'($urandom), ls, 1, 0, 8'h00, 0, 0);
    step(r8(), 1'($urandom), ls, 1, 0, m_read(a), 0, 0);
    got = ulpi_data_out;
    step(r8(), 1'($urandom), ls, 0, 0, 8'h00, 0, 0);
    step(r8(), 1'($urandom), ls, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d, input bit abort,
                    input int wait_n, input logic [1:0] ls);
    bit ok;
    step({2'b10, a}, 1'b0, ls, 0, 1, 8'h00, 0, 0);
    if (abort) begin
      step(r8(), 1'b1, ls, 0, 0, 8'h00, 0, 0);
    end else begin
      step(r8(), 1'b0, ls, 0, 1, 8'h00, 0, 0);
      step(d, 1'b0, ls, 0, 0, 8'h00, 0, 0);
      repeat (wait_n) step(r8(), 1'b0, ls, 0, 0, 8'h00, 0, 0);
      ok = m_write(a, d);
      if (ok) m_addr = a;
      step(r8(), 1'b1, ls, 0, 0, 8'h00, ok, 0);
    end
  endtask

  task automatic tx(input int n, input logic [1:0] ls, input int rst_at);
    int cnt;
    cnt = 0;
    nxt_hi = 0;
    step({2'b01, 6'($urandom)}, 1'b0, ls, 0, 1, 8'h00, 0, 0);
    if (NXT) nxt_hi++;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        do_reset(1);
        return;
      end
      step(r8(), 1'b0, ls, 0, 1, 8'h00, 0, 0);
      if (NXT) nxt_hi++;
      cnt = (cnt < 1023) ? cnt + 1 : 1023;
    end
    m_cnt = 10'(cnt);
    step(r8(), 1'b1, ls, 0, 0, 8'h00, 0, 1);
    if (NXT) nxt_hi++;
  endtask

  logic [5:0] wr_addrs [16] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                6'h0C, 6'h16, 6'h17, 6'h18, 6'h00, 6'h03, 6'h2F, 6'h19};

  initial begin
    logic [7:0] got;
    logic [1:0] ls;
    int kind;

    do_reset(2);
    chk("rst_dir", 32'(DIR), 32'd0);
    chk("rst_txcnt", 32'(tx_byte_count), 32'd0);

    rd(6'h00, 2'b00, got); chk("id0", 32'(got), 32'h24);
    rd(6'h01, 2'b00, got); chk("id1", 32'(got), 32'h04);
    rd(6'h02, 2'b00, got); chk("id2", 32'(got), 32'h07);
    rd(6'h03, 2'b00, got); chk("id3", 32'(got), 32'h00);

    wr(6'h16, 8'h55, 0, 0, 2'b00);
    chk("wr_addr_lit", 32'(reg_wr_addr), 32'h16);
    rd(6'h16, 2'b00, got); chk("scratch", 32'(got), 32'h55);

    rd(6'h04, 2'b00, got); chk("func_rst", 32'(got), 32'h41);
    wr(6'h05, 8'h04, 0, 1, 2'b00);
    rd(6'h04, 2'b00, got); chk("func_set", 32'(got), 32'h45);
    wr(6'h06, 8'h40, 0, 2, 2'b00);
    rd(6'h06, 2'b00, got); chk("func_clr", 32'(got), 32'h05);

    wr(6'h16, 8'hAA, 1, 0, 2'b00);
    rd(6'h16, 2'b00, got); chk("abort_keep", 32'(got), 32'h55);

    wr(6'h2F, 8'h77, 0, 0, 2'b00);
    rd(6'h2F, 2'b00, got); chk("ext_read", 32'(got), 32'h00);

    rd(6'h0A, 2'b01, got); chk("otg_rst", 32'(got), 32'h06);
    rx_seen = 8'hFF;
    idle(2'b01, 1'b0);
    chk("rxcmd", 32'(rx_seen), 32'h01);
    repeat (3) idle(2'b01, 1'b0);

    tx(5, 2'b01, -1);
    chk("tx_cnt5", 32'(tx_byte_count), 32'd5);
    chk("tx_nxt6", 32'(nxt_hi), 32'd6);
    tx(1030, 2'b01, -1);
    chk("tx_sat", 32'(tx_byte_count), 32'd1023);
    tx(0, 2'b01, -1);
    chk("tx_zero", 32'(tx_byte_count), 32'd0);
    tx(8, 2'b01, 3);
    chk("rst_nxt", 32'(NXT), 32'd0);
    rd(6'h04, 2'b01, got); chk("func_after_rst", 32'(got), 32'h41);

    ls = 2'b01;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) ls = 2'($urandom);
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1: wr(($urandom_range(0, 3) == 0) ? 6'($urandom) : wr_addrs[$urandom_range(0, 15)],
                 r8(), 1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), ls);
        2, 3: rd(($urandom_range(0, 1) == 0) ? 6'($urandom) : wr_addrs[$urandom_range(0, 15)],
                 ls, got);
        4:    tx(int'($urandom_range(0, 20)), ls, -1);
        5:    step({2'b00, 6'($urandom_range(1, 63))}, 1'($urandom), ls, 0, 0, 8'h00, 0, 0);
        6:    if ($urandom_range(0, 7) == 0) do_reset(1); else idle(ls, 1'b1);
        default: idle(ls, 1'b0);
      endcase
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
